tapped_delay_select: RTL and testbench

//   Parametrised, synthesizable WIDTH-bit delay line with DEPTH register stages.

---
 rtl/tapped_delay_select_if.sv | 28 ++
 rtl/tapped_delay_select.sv | 132 +++++++++++++
 tb/tb_tapped_delay_select.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tapped_delay_select_if.sv
// Bundle of the sample, tap-select and output signals of tapped_delay_select.
// The design takes the slave side and the sample source/consumer takes the master side.
interface tapped_delay_select_if #(
    parameter int WIDTH = 8,
    parameter int SEL_W = 2
);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic [SEL_W-1:0] sel_req;
    logic             sel_valid;
    logic             sel_ready;
    logic             sel_err;
    logic             assign_en;
    logic [WIDTH-1:0] dout;
    logic [SEL_W-1:0] dout_tap;
    logic             dout_valid;
    logic             chain_primed;

    modport master (
        output din, din_valid, sel_req, sel_valid, assign_en,
        input  sel_ready, sel_err, dout, dout_tap, dout_valid, chain_primed
    );

    modport slave (
        input  din, din_valid, sel_req, sel_valid, assign_en,
        output sel_ready, sel_err, dout, dout_tap, dout_valid, chain_primed
    );
endinterface

// File: rtl/tapped_delay_select.sv
// WIDTH-bit, DEPTH-stage delay line with a registered output that tracks or holds
// one run-time selectable tap; tap changes pass through a one-cycle SWITCH state.
module tapped_delay_select #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int SEL_W = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    tapped_delay_select_if.slave bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [SEL_W-1:0] MAX_SEL = SEL_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL    = CNT_W'(DEPTH);

    typedef enum logic [1:0] {HOLD, TRACK, SWITCH} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];
    logic [CNT_W-1:0] fill_q, fill_d;
    logic [SEL_W-1:0] cur_sel_q, cur_sel_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic [SEL_W-1:0] dout_tap_q, dout_tap_d;
    logic             dout_valid_q, dout_valid_d;
    logic             sel_err_q, sel_err_d;
    logic             sel_ready;
    logic             accept;
    logic [WIDTH-1:0] tap_val;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= HOLD;
        end else begin
            state_q <= state_d;
        end
    end

    // An accepted request wins over assign_en; otherwise assign_en alone picks TRACK/HOLD.
    always_comb begin
        state_d = state_q;
        if (accept) begin
            state_d = SWITCH;
        end else if (bus.assign_en) begin
            state_d = TRACK;
        end else begin
            state_d = HOLD;
        end
    end

    always_comb begin
        sel_ready = (state_q != SWITCH);
        accept    = bus.sel_valid && sel_ready;
    end

    always_comb begin
        tap_val = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (cur_sel_q == SEL_W'(i)) begin
                tap_val = stage_q[i];
            end
        end
    end

    always_comb begin
        stage_d      = stage_q;
        fill_d       = fill_q;
        cur_sel_d    = cur_sel_q;
        dout_d       = dout_q;
        dout_tap_d   = dout_tap_q;
        dout_valid_d = dout_valid_q;
        sel_err_d    = 1'b0;

        if (bus.din_valid) begin
            stage_d[0] = bus.din;
            for (int i = 1; i < DEPTH; i++) begin
                stage_d[i] = stage_q[i-1];
            end
            if (fill_q != FULL) begin
                fill_d = fill_q + CNT_W'(1);
            end
        end

        // The load uses pre-shift stage values and the tap that was current this cycle.
        if (state_q == TRACK) begin
            dout_d       = tap_val;
            dout_valid_d = (int'(fill_q) > int'(cur_sel_q));
        end

        if (state_q == SWITCH) begin
            dout_tap_d = cur_sel_q;
        end

        if (accept) begin
            if (bus.sel_req > MAX_SEL) begin
                cur_sel_d = MAX_SEL;
                sel_err_d = 1'b1;
            end else begin
                cur_sel_d = bus.sel_req;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
            fill_q       <= '0;
            cur_sel_q    <= '0;
            dout_q       <= '0;
            dout_tap_q   <= '0;
            dout_valid_q <= 1'b0;
            sel_err_q    <= 1'b0;
        end else begin
            stage_q      <= stage_d;
            fill_q       <= fill_d;
            cur_sel_q    <= cur_sel_d;
            dout_q       <= dout_d;
            dout_tap_q   <= dout_tap_d;
            dout_valid_q <= dout_valid_d;
            sel_err_q    <= sel_err_d;
        end
    end

    assign bus.sel_ready    = sel_ready;
    assign bus.sel_err      = sel_err_q;
    assign bus.dout         = dout_q;
    assign bus.dout_tap     = dout_tap_q;
    assign bus.dout_valid   = dout_valid_q;
    assign bus.chain_primed = (fill_q == FULL);
endmodule

// File: tb/tb_tapped_delay_select.sv
// Self-checking bench for tapped_delay_select: directed scenarios plus a randomized run,
// all compared against a queue-based reference model of the delay line and output rules.
module tb_tapped_delay_select;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int SEL_W = 3;

    localparam int M_HOLD   = 0;
    localparam int M_TRACK  = 1;
    localparam int M_SWITCH = 2;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   errors = 0;
    int   checks = 0;

    tapped_delay_select_if #(.WIDTH(WIDTH), .SEL_W(SEL_W)) bus ();

    tapped_delay_select #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SEL_W(SEL_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: newest sample at the front of m_hist, missing stages read as zero.
    logic [WIDTH-1:0] m_hist[$];
    int               m_mode;
    int               m_sel;
    int               m_tap;
    logic [WIDTH-1:0] m_dout;
    bit               m_dv;
    bit               m_err;

    function automatic logic [WIDTH-1:0] m_stage(int i);
        return (i < m_hist.size()) ? m_hist[i] : '0;
    endfunction

    function automatic void model_clear();
        m_hist.delete();
        m_mode = M_HOLD;
        m_sel  = 0;
        m_tap  = 0;
        m_dout = '0;
        m_dv   = 1'b0;
        m_err  = 1'b0;
    endfunction

    function automatic void model_step();
        bit acc;
        int fill;
        if (reset) begin
            model_clear();
            return;
        end
        acc  = bus.sel_valid && (m_mode != M_SWITCH);
        fill = m_hist.size();
        if (m_mode == M_TRACK) begin
            m_dout = m_stage(m_sel);
            m_dv   = (fill > m_sel);
        end
        if (m_mode == M_SWITCH) m_tap = m_sel;
        m_err = acc && (int'(bus.sel_req) >= DEPTH);
        if (acc) m_sel = (int'(bus.sel_req) < DEPTH) ? int'(bus.sel_req) : DEPTH - 1;
        m_mode = acc ? M_SWITCH : (bus.assign_en ? M_TRACK : M_HOLD);
        if (bus.din_valid) begin
            m_hist.push_front(bus.din);
            if (m_hist.size() > DEPTH) void'(m_hist.pop_back());
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle_inputs();
        bus.din       = '0;
        bus.din_valid = 1'b0;
        bus.sel_req   = '0;
        bus.sel_valid = 1'b0;
        bus.assign_en = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic push(input logic [WIDTH-1:0] value);
        bus.din       = value;
        bus.din_valid = 1'b1;
        tick();
        bus.din_valid = 1'b0;
    endtask

    task automatic test_reset();
        bus.din       = 8'h5A;
        bus.din_valid = 1'b1;
        bus.assign_en = 1'b1;
        bus.sel_valid = 1'b1;
        bus.sel_req   = 3'd7;
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if (bus.dout !== 8'h00) begin errors++; $display("[TB] FAIL reset_dout: got %h expected 00", bus.dout); end
        checks++;
        if (bus.dout_tap !== 3'd0) begin errors++; $display("[TB] FAIL reset_tap: got %0d expected 0", bus.dout_tap); end
        checks++;
        if (bus.dout_valid !== 1'b0 || bus.sel_err !== 1'b0 || bus.chain_primed !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_flags: got dv=%b err=%b primed=%b expected 0 0 0", bus.dout_valid, bus.sel_err, bus.chain_primed);
        end
        checks++;
        if (bus.sel_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 1", bus.sel_ready); end
        reset = 1'b0;
        idle_inputs();
    endtask

    task automatic test_fill_track();
        do_reset();
        bus.assign_en = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            push(WIDTH'(k));
            checks++;
            if (bus.dout !== WIDTH'((k == 1) ? 0 : k - 1)) begin
                errors++;
                $display("[TB] FAIL fill_dout[%0d]: got %h expected %h", k, bus.dout, WIDTH'((k == 1) ? 0 : k - 1));
            end
            checks++;
            if (bus.chain_primed !== (k >= DEPTH)) begin
                errors++;
                $display("[TB] FAIL fill_primed[%0d]: got %b expected %b", k, bus.chain_primed, (k >= DEPTH));
            end
            checks++;
            if (bus.dout !== m_dout) begin errors++; $display("[TB] FAIL fill_model[%0d]: got %h expected %h", k, bus.dout, m_dout); end
        end
    endtask

    task automatic test_switch();
        logic [WIDTH-1:0] samples [4];
        samples[0] = 8'hA1; samples[1] = 8'hB2; samples[2] = 8'hC3; samples[3] = 8'hD4;
        do_reset();
        for (int i = 0; i < 4; i++) push(samples[i]);
        bus.assign_en = 1'b1;
        bus.sel_req   = 3'd3;
        bus.sel_valid = 1'b1;
        tick();
        bus.sel_valid = 1'b0;
        checks++;
        if (bus.sel_ready !== 1'b0 || bus.dout !== 8'h00) begin
            errors++;
            $display("[TB] FAIL switch_enter: got ready=%b dout=%h expected 0 00", bus.sel_ready, bus.dout);
        end
        tick();
        checks++;
        if (bus.dout !== 8'h00 || bus.dout_tap !== 3'd3) begin
            errors++;
            $display("[TB] FAIL switch_leave: got dout=%h tap=%0d expected 00 3", bus.dout, bus.dout_tap);
        end
        tick();
        checks++;
        if (bus.dout !== 8'hA1 || bus.dout_tap !== 3'd3) begin
            errors++;
            $display("[TB] FAIL switch_load: got dout=%h tap=%0d expected a1 3", bus.dout, bus.dout_tap);
        end
    endtask

    task automatic test_hold();
        logic [WIDTH-1:0] held;
        logic [WIDTH-1:0] want;
        do_reset();
        for (int i = 0; i < 4; i++) push(WIDTH'($urandom));
        bus.assign_en = 1'b1;
        bus.sel_req   = 3'd1;
        bus.sel_valid = 1'b1;
        tick();
        bus.sel_valid = 1'b0;
        tick();
        push(WIDTH'($urandom));
        push(WIDTH'($urandom));
        bus.assign_en = 1'b0;
        tick();
        held = m_dout;
        checks++;
        if (bus.dout !== held) begin errors++; $display("[TB] FAIL hold_last: got %h expected %h", bus.dout, held); end
        for (int i = 0; i < 3; i++) begin
            push(WIDTH'($urandom));
            checks++;
            if (bus.dout !== held) begin errors++; $display("[TB] FAIL hold_frozen[%0d]: got %h expected %h", i, bus.dout, held); end
        end
        bus.assign_en = 1'b1;
        tick();
        want = m_stage(1);
        tick();
        checks++;
        if (bus.dout !== want) begin errors++; $display("[TB] FAIL hold_resume: got %h expected %h", bus.dout, want); end
    endtask

    task automatic test_clamp_back_to_back();
        bus.assign_en = 1'b1;
        bus.sel_req   = 3'd7;
        bus.sel_valid = 1'b1;
        tick();
        checks++;
        if (bus.sel_err !== 1'b1 || bus.sel_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL clamp_err: got err=%b ready=%b expected 1 0", bus.sel_err, bus.sel_ready);
        end
        bus.sel_req = 3'd0;
        tick();
        checks++;
        if (bus.sel_err !== 1'b0 || bus.dout_tap !== 3'd3 || bus.sel_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL clamp_stall: got err=%b tap=%0d ready=%b expected 0 3 1", bus.sel_err, bus.dout_tap, bus.sel_ready);
        end
        tick();
        bus.sel_valid = 1'b0;
        checks++;
        if (bus.sel_ready !== 1'b0 || bus.dout_tap !== 3'd3) begin
            errors++;
            $display("[TB] FAIL b2b_accept: got ready=%b tap=%0d expected 0 3", bus.sel_ready, bus.dout_tap);
        end
        tick();
        checks++;
        if (bus.dout_tap !== 3'd0) begin errors++; $display("[TB] FAIL b2b_tap: got %0d expected 0", bus.dout_tap); end
    endtask

    task automatic test_dout_valid();
        do_reset();
        bus.assign_en = 1'b1;
        bus.sel_req   = 3'd2;
        bus.sel_valid = 1'b1;
        tick();
        bus.sel_valid = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            push(WIDTH'($urandom));
            checks++;
            if (bus.dout_valid !== 1'b0) begin errors++; $display("[TB] FAIL dv_early[%0d]: got %b expected 0", i, bus.dout_valid); end
        end
        tick();
        checks++;
        if (bus.dout_valid !== 1'b1) begin errors++; $display("[TB] FAIL dv_filled: got %b expected 1", bus.dout_valid); end
    endtask

    task automatic test_reset_mid_switch();
        do_reset();
        bus.assign_en = 1'b1;
        for (int i = 0; i < 5; i++) push(WIDTH'($urandom_range(1, 255)));
        bus.sel_req   = 3'd2;
        bus.sel_valid = 1'b1;
        tick();
        bus.sel_valid = 1'b0;
        checks++;
        if (bus.sel_ready !== 1'b0) begin errors++; $display("[TB] FAIL midsw_in_switch: got ready=%b expected 0", bus.sel_ready); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (bus.dout !== 8'h00 || bus.dout_tap !== 3'd0 || bus.chain_primed !== 1'b0 ||
            bus.sel_ready !== 1'b1 || bus.dout_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midsw_reset: got dout=%h tap=%0d primed=%b ready=%b dv=%b expected 00 0 0 1 0",
                     bus.dout, bus.dout_tap, bus.chain_primed, bus.sel_ready, bus.dout_valid);
        end
        idle_inputs();
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 600; n++) begin
            reset         = ($urandom_range(0, 59) == 0);
            bus.din       = WIDTH'($urandom);
            bus.din_valid = ($urandom_range(0, 1) == 1);
            bus.sel_valid = ($urandom_range(0, 3) == 0);
            bus.sel_req   = SEL_W'($urandom_range(0, 7));
            if ($urandom_range(0, 7) == 0) bus.assign_en = ~bus.assign_en;
            tick();
            checks++;
            if (bus.dout !== m_dout) begin errors++; $display("[TB] FAIL rand_dout[%0d]: got %h expected %h", n, bus.dout, m_dout); end
            checks++;
            if (bus.dout_tap !== SEL_W'(m_tap)) begin errors++; $display("[TB] FAIL rand_tap[%0d]: got %0d expected %0d", n, bus.dout_tap, m_tap); end
            checks++;
            if (bus.dout_valid !== m_dv) begin errors++; $display("[TB] FAIL rand_dv[%0d]: got %b expected %b", n, bus.dout_valid, m_dv); end
            checks++;
            if (bus.sel_err !== m_err) begin errors++; $display("[TB] FAIL rand_err[%0d]: got %b expected %b", n, bus.sel_err, m_err); end
            checks++;
            if (bus.sel_ready !== (m_mode != M_SWITCH)) begin
                errors++;
                $display("[TB] FAIL rand_ready[%0d]: got %b expected %b", n, bus.sel_ready, (m_mode != M_SWITCH));
            end
            checks++;
            if (bus.chain_primed !== (m_hist.size() == DEPTH)) begin
                errors++;
                $display("[TB] FAIL rand_primed[%0d]: got %b expected %b", n, bus.chain_primed, (m_hist.size() == DEPTH));
            end
        end
        reset = 1'b0;
        idle_inputs();
    endtask

    initial begin
        model_clear();
        idle_inputs();
        #2;
        test_reset();
        test_fill_track();
        test_switch();
        test_hold();
        test_clamp_back_to_back();
        test_dout_valid();
        test_reset_mid_switch();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
